traffic_monitor: RTL and testbench

TRAFFIC_MONITOR -- requirements
Module: traffic_monitor

---
 rtl/traffic_monitor.sv | 153 +++++++++++++++
 tb/tb_traffic_monitor.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/traffic_monitor.sv
// Traffic-light protocol monitor.
// Watches a RED/GREEN/YELLOW light code plus its advance request, locks onto
// the sequence at the first forced RED, then flags and counts protocol
// violations and counts completed RED->GREEN->YELLOW->RED rounds.
// Optional dwell counter is built only when TRAFFIC_MONITOR_DWELL_EN is defined;
// otherwise dwell is tied to zero.
module traffic_monitor #(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned ERR_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in,
  input  logic [1:0]       light,
  input  logic             clr,
  output logic             red,
  output logic             green,
  output logic             yellow,
  output logic             sync,
  output logic             err,
  output logic [ERR_W-1:0] err_cnt,
  output logic [CNT_W-1:0] cycles,
  output logic [CNT_W-1:0] dwell
);

  localparam logic [1:0] LightRed     = 2'b10;
  localparam logic [1:0] LightGreen   = 2'b11;
  localparam logic [1:0] LightYellow  = 2'b01;
  localparam logic [1:0] LightIllegal = 2'b00;

  localparam logic [0:0] StUnsync = 1'b0;
  localparam logic [0:0] StTrack  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [1:0]       prev_light_q;
  logic             prev_in_q;
  logic             red_q, green_q, yellow_q;
  logic             red_d, green_d, yellow_d;
  logic             err_q, err_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [1:0]       expected;
  logic             track;
  logic             viol;
  logic             round_done;

  // Code the light must show this cycle, given last cycle's code and request.
  always_comb begin
    expected = LightRed;
    if (prev_in_q) begin
      case (prev_light_q)
        LightRed:    expected = LightGreen;
        LightGreen:  expected = LightYellow;
        LightYellow: expected = LightRed;
        // After an illegal code the only sensible recovery target is RED.
        default:     expected = LightRed;
      endcase
    end
  end

  // Lock/violation/round detection and next-state of the counters.
  always_comb begin
    track      = (state_q == StTrack);
    viol       = track && ((light == LightIllegal) || (light != expected));
    round_done = track && prev_in_q && (prev_light_q == LightYellow) && (light == LightRed);

    state_d = state_q;
    if ((state_q == StUnsync) && (light == LightRed) && !prev_in_q) begin
      state_d = StTrack;
    end

    err_d     = err_q | viol;
    err_cnt_d = err_cnt_q;
    if (viol && (err_cnt_q != {ERR_W{1'b1}})) begin
      err_cnt_d = err_cnt_q + ERR_W'(1);
    end
    cycles_d = round_done ? cycles_q + CNT_W'(1) : cycles_q;

    // Clear beats any same-cycle increment.
    if (clr) begin
      err_d     = 1'b0;
      err_cnt_d = '0;
      cycles_d  = '0;
    end

    red_d    = (light == LightRed);
    green_d  = (light == LightGreen);
    yellow_d = (light == LightYellow);
  end

  // Monitor state, sampled light/request history and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StUnsync;
      prev_light_q <= LightIllegal;
      prev_in_q    <= 1'b0;
      red_q        <= 1'b0;
      green_q      <= 1'b0;
      yellow_q     <= 1'b0;
      err_q        <= 1'b0;
      err_cnt_q    <= '0;
      cycles_q     <= '0;
    end else begin
      state_q      <= state_d;
      prev_light_q <= light;
      prev_in_q    <= in;
      red_q        <= red_d;
      green_q      <= green_d;
      yellow_q     <= yellow_d;
      err_q        <= err_d;
      err_cnt_q    <= err_cnt_d;
      cycles_q     <= cycles_d;
    end
  end

`ifdef TRAFFIC_MONITOR_DWELL_EN
  logic [CNT_W-1:0] dwell_q, dwell_d;

  // Dwell restarts at 1 on a code change, saturates, and is idle until locked.
  always_comb begin
    dwell_d = dwell_q;
    if (!track) begin
      dwell_d = '0;
    end else if (light != prev_light_q) begin
      dwell_d = CNT_W'(1);
    end else if (dwell_q != {CNT_W{1'b1}}) begin
      dwell_d = dwell_q + CNT_W'(1);
    end
  end

  // Dwell counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_q <= '0;
    end else begin
      dwell_q <= dwell_d;
    end
  end

  assign dwell = dwell_q;
`else
  assign dwell = '0;
`endif

  assign red     = red_q;
  assign green   = green_q;
  assign yellow  = yellow_q;
  assign sync    = (state_q == StTrack);
  assign err     = err_q;
  assign err_cnt = err_cnt_q;
  assign cycles  = cycles_q;

endmodule

// File: tb/tb_traffic_monitor.sv
// Directed self-checking bench for traffic_monitor (default parameters).
// Dwell expectations follow whether TRAFFIC_MONITOR_DWELL_EN is defined.
module tb_traffic_monitor;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned ERR_W = 4;

`ifdef TRAFFIC_MONITOR_DWELL_EN
  localparam bit DwellEn = 1'b1;
`else
  localparam bit DwellEn = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n;
  logic             in;
  logic [1:0]       light;
  logic             clr;
  logic             red, green, yellow, sync, err;
  logic [ERR_W-1:0] err_cnt;
  logic [CNT_W-1:0] cycles;
  logic [CNT_W-1:0] dwell;

  int total_cnt = 0;
  int pass_cnt  = 0;

  traffic_monitor #(
    .CNT_W (CNT_W),
    .ERR_W (ERR_W)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .in      (in),
    .light   (light),
    .clr     (clr),
    .red     (red),
    .green   (green),
    .yellow  (yellow),
    .sync    (sync),
    .err     (err),
    .err_cnt (err_cnt),
    .cycles  (cycles),
    .dwell   (dwell)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total_cnt++;
    assert (obs === exp_v) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] l, input logic i);
    light = l;
    in    = i;
  endtask

  initial begin
    rst_n = 1'b0;
    in    = 1'b0;
    light = 2'b00;
    clr   = 1'b0;
    #2;
    chk("rst_red", 32'(red), 32'd0);
    chk("rst_sync", 32'(sync), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_err_cnt", 32'(err_cnt), 32'd0);
    chk("rst_cycles", 32'(cycles), 32'd0);
    chk("rst_dwell", 32'(dwell), 32'd0);
    #10;
    rst_n = 1'b1;

    // Forced RED locks the monitor.
    drive(2'b10, 1'b0);
    tick();
    chk("lock_sync", 32'(sync), 32'd1);
    chk("lock_red", 32'(red), 32'd1);
    tick();
    chk("lock2_sync", 32'(sync), 32'd1);
    chk("lock2_err", 32'(err), 32'd0);
    chk("lock2_cycles", 32'(cycles), 32'd0);

    // Full round RED->GREEN->YELLOW->RED.
    drive(2'b10, 1'b1); tick();
    drive(2'b11, 1'b1); tick();
    chk("round_green", 32'(green), 32'd1);
    chk("round_dwell_chg", 32'(dwell), DwellEn ? 32'd1 : 32'd0);
    drive(2'b01, 1'b1); tick();
    chk("round_yellow", 32'(yellow), 32'd1);
    chk("round_cycles_mid", 32'(cycles), 32'd0);
    drive(2'b10, 1'b0); tick();
    chk("round_cycles", 32'(cycles), 32'd1);
    chk("round_err", 32'(err), 32'd0);
    chk("round_err_cnt", 32'(err_cnt), 32'd0);
    tick();
    chk("round_hold_err", 32'(err), 32'd0);

    // RED followed by YELLOW under advance: violation, sticky err.
    drive(2'b10, 1'b1); tick();
    chk("pre_viol_err", 32'(err), 32'd0);
    drive(2'b01, 1'b1); tick();
    chk("viol_err", 32'(err), 32'd1);
    chk("viol_err_cnt", 32'(err_cnt), 32'd1);
    drive(2'b10, 1'b0); tick();
    chk("viol_legal_err", 32'(err), 32'd1);
    chk("viol_legal_cnt", 32'(err_cnt), 32'd1);
    chk("viol_legal_cycles", 32'(cycles), 32'd2);
    tick();
    chk("viol_sticky", 32'(err), 32'd1);

    // Illegal code for 20 cycles saturates the error counter.
    drive(2'b00, 1'b0); tick();
    chk("illegal_cnt1", 32'(err_cnt), 32'd2);
    chk("illegal_decode", 32'({red, green, yellow}), 32'd0);
    for (int k = 0; k < 19; k++) tick();
    chk("illegal_sat", 32'(err_cnt), 32'd15);
    chk("illegal_err", 32'(err), 32'd1);

    // Clear zeroes counters, keeps lock.
    clr = 1'b1;
    drive(2'b10, 1'b0); tick();
    chk("clr_err", 32'(err), 32'd0);
    chk("clr_err_cnt", 32'(err_cnt), 32'd0);
    chk("clr_cycles", 32'(cycles), 32'd0);
    chk("clr_sync", 32'(sync), 32'd1);
    // Clear beats a simultaneous violation.
    drive(2'b00, 1'b0); tick();
    chk("clr_wins_err", 32'(err), 32'd0);
    chk("clr_wins_cnt", 32'(err_cnt), 32'd0);
    clr = 1'b0;

    // Long RED hold: dwell saturates (or stays 0 without the feature).
    drive(2'b10, 1'b0); tick();
    chk("dwell_start", 32'(dwell), DwellEn ? 32'd1 : 32'd0);
    chk("hold_err", 32'(err), 32'd0);
    for (int k = 0; k < 299; k++) tick();
    chk("dwell_sat", 32'(dwell), DwellEn ? 32'd255 : 32'd0);
    chk("hold_err_end", 32'(err), 32'd0);

    // Reset mid-GREEN drops the lock.
    drive(2'b10, 1'b1); tick();
    drive(2'b11, 1'b1); tick();
    chk("pre_rst_green", 32'(green), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_green", 32'(green), 32'd0);
    chk("async_sync", 32'(sync), 32'd0);
    chk("async_dwell", 32'(dwell), 32'd0);
    #3;
    rst_n = 1'b1;
    drive(2'b11, 1'b1); tick();
    chk("post_rst_sync", 32'(sync), 32'd0);
    chk("post_rst_err", 32'(err), 32'd0);
    chk("post_rst_green", 32'(green), 32'd1);
    drive(2'b10, 1'b1); tick();
    chk("red_adv_nosync", 32'(sync), 32'd0);
    drive(2'b10, 1'b0); tick();
    chk("red_prev_adv_nosync", 32'(sync), 32'd0);
    tick();
    chk("resync", 32'(sync), 32'd1);
    chk("resync_err", 32'(err), 32'd0);
    chk("resync_red", 32'(red), 32'd1);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
